// File: rtl/serial_sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM encoding, nibble width
// and step-counter sizing.
`timescale 1ns/1ps
package serial_sub_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned NIB = 4;

    // Counter width for n steps; at least one bit so a single-nibble build still elaborates.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/fast_sub4.sv
// Combinational 4-bit borrow-lookahead subtractor: diff = a - b - b_in.
`timescale 1ns/1ps
module fast_sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       b_in,
    output logic [3:0] diff,
    output logic       b_out
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] bw;

    always_comb begin
        p     = ~(a ^ b);
        g     = ~a & b;
        bw[0] = b_in;
        // Flattened lookahead: every borrow depends only on p, g and b_in.
        bw[1] = g[0] | (p[0] & b_in);
        bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & b_in);
        bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & b_in);
        bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & b_in);
        diff  = a ^ b ^ bw[3:0];
        b_out = bw[4];
    end

endmodule

// File: rtl/serial_sub16.sv
// Nibble-serial subtractor computing a - b - b_in over WIDTH bits, one nibble per clock.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
`timescale 1ns/1ps
module serial_sub16
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             b_out
);

    localparam int unsigned N  = WIDTH / NIB;
    localparam int unsigned CW = clog2(N);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             bw_q, bw_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_out_q, b_out_d;

    logic [NIB-1:0]       nib_diff;
    logic                 nib_bout;
    logic [WIDTH+NIB-1:0] res_cat;
    logic [WIDTH-1:0]     res_shift;
    logic                 last_step;

    fast_sub4 u_fast_sub4 (
        .a     (a_q[NIB-1:0]),
        .b     (b_q[NIB-1:0]),
        .b_in  (bw_q),
        .diff  (nib_diff),
        .b_out (nib_bout)
    );

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept apart because a_q/b_q shift out as they are consumed.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        // New nibble enters at the top, so after N steps nibble 0 sits at the LSBs.
        res_cat   = {nib_diff, res_q};
        res_shift = res_cat[WIDTH+NIB-1:NIB];
        last_step = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        bw_d    = bw_q;
        res_d   = res_q;
        diff_d  = diff_q;
        b_out_d = b_out_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    bw_d    = b_in;
                    res_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d   = a_q >> NIB;
                b_d   = b_q >> NIB;
                bw_d  = nib_bout;
                res_d = res_shift;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    state_d = StDone;
                    diff_d  = res_shift;
                    b_out_d = nib_bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            bw_q    <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bw_q    <= bw_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            b_out_q <= b_out_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);
    assign diff  = diff_q;
    assign b_out = b_out_q;

endmodule

// File: tb/tb_serial_sub16.sv
// Scoreboard bench for serial_sub16: driver pushes expected results, monitor pops on done.
`timescale 1ns/1ps
module tb_serial_sub16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        b_in  = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        b_out;
`ifdef SERIAL_SUB_OVF_EN
    logic        ovf;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   passed   = 0;
    int   total    = 0;
    int   done_cnt = 0;
    int   cyc      = 0;

    serial_sub16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .b_out (b_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called on a falling edge; the accepting rising edge is the next one.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                         input bit push, input logic [15:0] ed, input logic eb, input logic eo);
        a     = av;
        b     = bv;
        b_in  = bi;
        start = 1'b1;
        if (push) sb_q.push_back('{d: ed, bo: eb, ov: eo, acc: cyc + 1});
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                e = sb_q.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("b_out", 32'(b_out), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ov));
`endif
                check("latency", 32'(cyc - e.acc), 32'd4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1);
    end

    initial begin
        int bc;
        int dc0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_b_out", 32'(b_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Basic subtraction with busy/done timing.
        issue(16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        for (int i = 0; i < 4; i++) begin
            bc += int'(busy);
            check("t1_no_early_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        check("t1_busy_cycles", 32'(bc), 32'd4);
        check("t1_done_now", 32'(done), 32'd1);
        check("t1_busy_low_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("t1_done_single", 32'(done), 32'd0);

        // Underflow wraps and borrows out.
        issue(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done("t2");
        @(negedge clk);

        // Signed overflow case.
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done("t3");
        @(negedge clk);

        // Reset during step 2 aborts without a done.
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        dc0   = done_cnt;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_b_out", 32'(b_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(dc0));
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done("t5");
        @(negedge clk);

        // Start while busy is ignored; operands may change after acceptance.
        dc0 = done_cnt;
        issue(16'h0010, 16'h000F, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        issue(16'hFFFF, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        a     = 16'h5555;
        b     = 16'hAAAA;
        wait_done("t4");
        repeat (4) @(negedge clk);
        check("t4_single_done", 32'(done_cnt), 32'(dc0 + 1));

        // Back-to-back: new start during the DONE cycle.
        issue(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h00FE, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done("t6a");
        issue(16'h0001, 16'h0002, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("t6_busy_again", 32'(busy), 32'd1);
        check("t6_diff_held", 32'(diff), 32'h00FE);
        wait_done("t6b");
        @(negedge clk);

        check("total_dones", 32'(done_cnt), 32'd7);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_sub16.md
# serial_sub16

Multi-cycle unsigned/two's-complement subtractor: computes A − B − borrow_in over a WIDTH-bit word, one 4-bit nibble per clock. Each nibble passes through a 4-bit borrow-lookahead stage, and the borrow is registered between nibbles. It is the subtract counterpart to the team's 4-bit carry-lookahead adder and sits in the datapath wherever a wide difference is needed and a few cycles of latency are acceptable. A start/busy/done handshake sequences operations.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- b_in  input  1  borrow in; captured on accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  single-cycle pulse; result is valid.
- diff  output  WIDTH  result (a − b − b_in) mod 2^WIDTH.
- b_out  output  1  final borrow; 1 iff a < b + b_in (unsigned).
- ovf  output  1  signed overflow; exists only when SERIAL_SUB_OVF_EN is defined.

## Operation
- N = WIDTH/4 nibble steps.
- FSM states:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, step counter 0..N−1.
  - DONE: done=1 for exactly one cycle.
- State transitions:
  - IDLE or DONE with start=1 → RUN. a, b and b_in are latched and the counter is cleared.
  - RUN with counter=N−1 → DONE.
  - DONE with start=0 → IDLE.
- start is ignored in RUN. The operand inputs may change freely after acceptance.
- Per nibble i, using operand bits [4i+3:4i] and the registered borrow:
  - propagate p = ~(a^b)
  - generate g = ~a & b
  - borrow chain: bw[j+1] = g[j] | (p[j] & bw[j])
  - difference: d = a ^ b ^ bw[3:0]
- The nibble-0 borrow is b_in. Each subsequent nibble uses the borrow out of the previous nibble, which is registered.
- Result nibbles collect in an internal shift register.
- diff, b_out and ovf are updated only on the RUN→DONE edge. They hold their values through IDLE and through the following RUN until the next completion.
- ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands.
- Reset values: state IDLE; busy=0, done=0, diff=0, b_out=0, ovf=0; internal registers cleared.
- Reset asserted mid-RUN aborts the operation. No done is produced, and outputs return to their reset values.

## Timing
- start is accepted at rising edge k. busy goes high after edge k.
- Nibble i is computed in the cycle after edge k+i.
- done=1, busy=0, and diff/b_out/ovf are valid in the cycle after edge k+N. Latency is N cycles (4 for WIDTH=16).
- Throughput: a start held or re-asserted during the DONE cycle is accepted on that edge. Back-to-back operations therefore issue every N+1 cycles.
- There is no combinational path from inputs to outputs; all outputs are registered.

## Configuration
- SERIAL_SUB_OVF_EN:
  - Defined: the ovf port and its register exist, behaving as specified above.
  - Undefined: the port and logic are absent. All other behaviour and timing are identical.

## Structure
- The package serial_sub_pkg holds:
  - the state encoding (IDLE, RUN, DONE)
  - the nibble width constant NIB = 4
  - the step-counter width function clog2(WIDTH/4)
- Sub-module fast_sub4: combinational 4-bit borrow-lookahead subtractor.
  - Ports: a[3:0], b[3:0], b_in, diff[3:0], b_out.
  - Instantiated once and reused every step.

## Test plan
All scenarios use WIDTH=16.
- 0x1234 − 0x0234, b_in=0 → diff=0x1000, b_out=0, ovf=0; done exactly 4 cycles after start; busy high for 4 cycles.
- 0x0000 − 0x0001, b_in=0 → diff=0xFFFF, b_out=1, ovf=0.
- 0x8000 − 0x0001 → diff=0x7FFF, b_out=0, ovf=1 with the macro defined; ovf port absent without it.
- Start 0x0010 − 0x000F with b_in=1. While busy, pulse start with different operands and change a/b → result diff=0x0000, b_out=0; the second start is ignored and done pulses exactly once.
- Drop rst_n for one cycle during step 2 of 0xFFFF − 0x0001 → busy=0, done never pulses, diff=0, b_out=0. The next start completes normally.
- Assert start during the DONE cycle of 0x00FF − 0x0001 with new operands 0x0001 − 0x0002 → first result 0x00FE, then a second done 4 cycles later with diff=0xFFFF, b_out=1.
